// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, total-length helpers, colour codes and the
// configuration payload handed to the pixel generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam int unsigned DEF_PIX_DIV   = 4;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned COLOR_W = 3;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t COLOR_BLACK   = 3'b000;
  localparam color_t COLOR_BLUE    = 3'b001;
  localparam color_t COLOR_GREEN   = 3'b010;
  localparam color_t COLOR_CYAN    = 3'b011;
  localparam color_t COLOR_RED     = 3'b100;
  localparam color_t COLOR_MAGENTA = 3'b101;
  localparam color_t COLOR_YELLOW  = 3'b110;
  localparam color_t COLOR_WHITE   = 3'b111;

  typedef struct packed {
    color_t control0;
    color_t control1;
    color_t control2;
    logic   mode;
  } pix_cfg_t;

  function automatic int unsigned h_total(input int unsigned disp, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned disp, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate enable: free-running 0..PIX_DIV-1 counter, p_tick high while
// the counter sits at its last value.
module pix_tick_div #(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // p_tick is registered from the next count so it tracks cnt_q == LAST exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      p_tick <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_tick <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing: pixel/line counters, registered syncs, frame pulse and
// the applied pixel-generator configuration. Define FRAME_LATCH_EN to make
// the configuration update only at frame wrap.
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned PIX_DIV   = DEF_PIX_DIV
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  control0_in,
  input  logic [2:0]  control1_in,
  input  logic [2:0]  control2_in,
  input  logic        mode_in,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        p_tick,
  output logic        frame_start,
  output logic [2:0]  control0,
  output logic [2:0]  control1,
  output logic [2:0]  control2,
  output logic        mode
);

  localparam int unsigned H_TOTAL = h_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_DISPLAY, V_FP, V_SYNC, V_BP);

  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_DISPLAY);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_DISPLAY);
  localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_DISPLAY + H_FP);
  localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_DISPLAY + V_FP);
  localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [COUNT_W-1:0] x_d;
  logic [COUNT_W-1:0] y_d;
  logic               line_end;
  logic               wrap;
  pix_cfg_t           cfg_in;
  pix_cfg_t           cfg_q;

  pix_tick_div #(
    .PIX_DIV (PIX_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );

  // Next raster position; both counts fall to (0,0) together at frame end
  always_comb begin
    x_d      = pixel_x;
    y_d      = pixel_y;
    line_end = (pixel_x == H_LAST);
    wrap     = p_tick && line_end && (pixel_y == V_LAST);
    if (p_tick) begin
      if (line_end) begin
        x_d = '0;
        y_d = (pixel_y == V_LAST) ? '0 : pixel_y + COUNT_W'(1);
      end else begin
        x_d = pixel_x + COUNT_W'(1);
      end
    end
  end

  // Syncs decode the next counts so they line up with the count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= x_d;
      pixel_y     <= y_d;
      hsync       <= !((x_d >= HS_START) && (x_d <= HS_END));
      vsync       <= !((y_d >= VS_START) && (y_d <= VS_END));
      frame_start <= wrap;
    end
  end

  assign video_on = (pixel_x < H_VIS) && (pixel_y < V_VIS);

  assign cfg_in = '{control0: control0_in, control1: control1_in,
                    control2: control2_in, mode: mode_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q <= '{control0: COLOR_BLACK, control1: COLOR_BLACK,
                 control2: COLOR_BLACK, mode: 1'b0};
    end else begin
`ifdef FRAME_LATCH_EN
      if (wrap) cfg_q <= cfg_in;
`else
      cfg_q <= cfg_in;
`endif
    end
  end

  assign control0 = cfg_q.control0;
  assign control1 = cfg_q.control1;
  assign control2 = cfg_q.control2;
  assign mode     = cfg_q.mode;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench for vga_sync_ctrl: a shrunken-timing instance for whole
// frames and a default-timing instance for the first lines.
module tb_vga_sync_ctrl;

  // Small raster: H_TOTAL = 15 (hsync low x 10..12), V_TOTAL = 10 (vsync low y 7..8)
  localparam int S_HT = 15;
  localparam int S_VT = 10;
  localparam int S_FRAME_CLK = S_HT * S_VT * 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  control0_in, control1_in, control2_in;
  logic        mode_in;

  logic [15:0] s_x, s_y, d_x, d_y;
  logic        s_von, s_hs, s_vs, s_pt, s_fs, s_mode;
  logic        d_von, d_hs, d_vs, d_pt, d_fs, d_mode;
  logic [2:0]  s_c0, s_c1, s_c2, d_c0, d_c1, d_c2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_sync_ctrl #(
    .H_DISPLAY (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_DISPLAY (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIX_DIV   (4)
  ) u_small (
    .clk (clk), .reset_n (reset_n),
    .control0_in (control0_in), .control1_in (control1_in),
    .control2_in (control2_in), .mode_in (mode_in),
    .pixel_x (s_x), .pixel_y (s_y), .video_on (s_von),
    .hsync (s_hs), .vsync (s_vs), .p_tick (s_pt), .frame_start (s_fs),
    .control0 (s_c0), .control1 (s_c1), .control2 (s_c2), .mode (s_mode)
  );

  vga_sync_ctrl u_dflt (
    .clk (clk), .reset_n (reset_n),
    .control0_in (control0_in), .control1_in (control1_in),
    .control2_in (control2_in), .mode_in (mode_in),
    .pixel_x (d_x), .pixel_y (d_y), .video_on (d_von),
    .hsync (d_hs), .vsync (d_vs), .p_tick (d_pt), .frame_start (d_fs),
    .control0 (d_c0), .control1 (d_c1), .control2 (d_c2), .mode (d_mode)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    control0_in = 3'b101; control1_in = 3'b011; control2_in = 3'b110; mode_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s_x !== 16'd0 || s_y !== 16'd0) begin n_fail++;
      $display("FAIL reset_small_xy got (%0d,%0d) exp (0,0)", s_x, s_y); end
    n_checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1) begin n_fail++;
      $display("FAIL reset_small_sync got hs=%b vs=%b exp 1 1", s_hs, s_vs); end
    n_checks++; if (s_pt !== 1'b0 || s_fs !== 1'b0) begin n_fail++;
      $display("FAIL reset_small_pulses got pt=%b fs=%b exp 0 0", s_pt, s_fs); end
    n_checks++; if ({s_c0, s_c1, s_c2, s_mode} !== 10'd0) begin n_fail++;
      $display("FAIL reset_small_cfg got %h exp 0", {s_c0, s_c1, s_c2, s_mode}); end
    n_checks++; if (s_von !== 1'b1) begin n_fail++;
      $display("FAIL reset_small_von got %b exp 1", s_von); end
    n_checks++; if (d_x !== 16'd0 || d_y !== 16'd0 || d_hs !== 1'b1 || d_vs !== 1'b1) begin n_fail++;
      $display("FAIL reset_dflt got x=%0d y=%0d hs=%b vs=%b exp 0 0 1 1", d_x, d_y, d_hs, d_vs); end
    n_checks++; if (d_pt !== 1'b0 || d_fs !== 1'b0 || {d_c0, d_c1, d_c2, d_mode} !== 10'd0) begin n_fail++;
      $display("FAIL reset_dflt_misc got pt=%b fs=%b cfg=%h exp 0 0 0", d_pt, d_fs, {d_c0, d_c1, d_c2, d_mode}); end
    reset_n = 1'b1;
  endtask

  // Position after k clk edges from release is n = k/4 pixel periods
  task automatic test_frame_scan();
    int n, ex, ey, dx, dy, fs_cnt, pt_cnt, hs_low;
    logic e_hs, e_vs, e_von;
    fs_cnt = 0; pt_cnt = 0; hs_low = 0;
    for (int k = 1; k <= 6500; k++) begin
      @(posedge clk);
      #1;
      n  = k / 4;
      ex = n % S_HT;
      ey = (n / S_HT) % S_VT;
      e_hs  = !(ex >= 10 && ex <= 12);
      e_vs  = !(ey >= 7 && ey <= 8);
      e_von = (ex < 8) && (ey < 6);
      if (s_fs) fs_cnt++;
      if (k <= S_FRAME_CLK && s_pt) pt_cnt++;
      n_checks++; if (s_x !== 16'(ex) || s_y !== 16'(ey)) begin n_fail++;
        $display("FAIL scan_xy k=%0d got (%0d,%0d) exp (%0d,%0d)", k, s_x, s_y, ex, ey); end
      n_checks++; if (s_hs !== e_hs) begin n_fail++;
        $display("FAIL scan_hsync k=%0d x=%0d got %b exp %b", k, ex, s_hs, e_hs); end
      n_checks++; if (s_vs !== e_vs) begin n_fail++;
        $display("FAIL scan_vsync k=%0d y=%0d got %b exp %b", k, ey, s_vs, e_vs); end
      n_checks++; if (s_von !== e_von) begin n_fail++;
        $display("FAIL scan_video_on k=%0d got %b exp %b", k, s_von, e_von); end
      n_checks++; if (s_pt !== (k % 4 == 3)) begin n_fail++;
        $display("FAIL scan_p_tick k=%0d got %b exp %b", k, s_pt, (k % 4 == 3)); end
      n_checks++; if (s_fs !== (k % S_FRAME_CLK == 0)) begin n_fail++;
        $display("FAIL scan_frame_start k=%0d got %b exp %b", k, s_fs, (k % S_FRAME_CLK == 0)); end
      if (k <= 6400) begin
        dx = n % 800;
        dy = n / 800;
        if (k <= 3200 && d_pt && !d_hs) hs_low++;
        n_checks++; if (d_x !== 16'(dx) || d_y !== 16'(dy)) begin n_fail++;
          $display("FAIL dflt_xy k=%0d got (%0d,%0d) exp (%0d,%0d)", k, d_x, d_y, dx, dy); end
        n_checks++; if (d_hs !== !(dx >= 656 && dx <= 751)) begin n_fail++;
          $display("FAIL dflt_hsync k=%0d x=%0d got %b", k, dx, d_hs); end
        n_checks++; if (d_von !== (dx < 640) || d_vs !== 1'b1 || d_fs !== 1'b0) begin n_fail++;
          $display("FAIL dflt_von k=%0d x=%0d got von=%b vs=%b fs=%b", k, dx, d_von, d_vs, d_fs); end
        n_checks++; if (d_pt !== (k % 4 == 3)) begin n_fail++;
          $display("FAIL dflt_p_tick k=%0d got %b", k, d_pt); end
      end
    end
    n_checks++; if (fs_cnt != 10) begin n_fail++;
      $display("FAIL scan_frame_count got %0d exp 10", fs_cnt); end
    n_checks++; if (pt_cnt != 150) begin n_fail++;
      $display("FAIL scan_ticks_per_frame got %0d exp 150", pt_cnt); end
    n_checks++; if (hs_low != 96) begin n_fail++;
      $display("FAIL dflt_hsync_width got %0d exp 96", hs_low); end
  endtask

  // control0_in changes on line 4 of the second frame (k = 600 + 240)
  task automatic test_control();
    logic [2:0] e_c0, e_c1, e_c2;
    logic       e_mode;
    reset_n = 1'b0;
    control0_in = 3'b001; control1_in = 3'b010; control2_in = 3'b111; mode_in = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 1210; k++) begin
      @(posedge clk);
      #1;
`ifdef FRAME_LATCH_EN
      e_c0   = (k < 600) ? 3'b000 : (k < 1200) ? 3'b001 : 3'b100;
      e_c1   = (k < 600) ? 3'b000 : 3'b010;
      e_c2   = (k < 600) ? 3'b000 : 3'b111;
      e_mode = (k >= 600);
`else
      e_c0   = (k <= 840) ? 3'b001 : 3'b100;
      e_c1   = 3'b010;
      e_c2   = 3'b111;
      e_mode = 1'b1;
`endif
      if (k == 1 || k == 599 || k == 600 || k == 840 || k == 841 || k == 1199 || k == 1200) begin
        n_checks++; if (s_c0 !== e_c0) begin n_fail++;
          $display("FAIL ctrl_control0 k=%0d got %b exp %b", k, s_c0, e_c0); end
        n_checks++; if (s_c1 !== e_c1 || s_c2 !== e_c2 || s_mode !== e_mode) begin n_fail++;
          $display("FAIL ctrl_other k=%0d got %b %b %b exp %b %b %b", k, s_c1, s_c2, s_mode, e_c1, e_c2, e_mode); end
      end
      if (k == 840) control0_in = 3'b100;
    end
  endtask

  // Reset pulsed between clk edges at small pixel (5,3), default pixel (50,0)
  task automatic test_mid_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    n_checks++; if (s_x !== 16'd5 || s_y !== 16'd3 || d_x !== 16'd50) begin n_fail++;
      $display("FAIL midrst_pre got s=(%0d,%0d) d=%0d exp (5,3) 50", s_x, s_y, d_x); end
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (s_x !== 16'd0 || s_y !== 16'd0 || d_x !== 16'd0 || d_y !== 16'd0) begin n_fail++;
      $display("FAIL midrst_xy got s=(%0d,%0d) d=(%0d,%0d) exp zeros", s_x, s_y, d_x, d_y); end
    n_checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_pt !== 1'b0 || s_fs !== 1'b0) begin n_fail++;
      $display("FAIL midrst_ctl got hs=%b vs=%b pt=%b fs=%b exp 1 1 0 0", s_hs, s_vs, s_pt, s_fs); end
    n_checks++; if ({s_c0, s_c1, s_c2, s_mode} !== 10'd0) begin n_fail++;
      $display("FAIL midrst_cfg got %h exp 0", {s_c0, s_c1, s_c2, s_mode}); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 601; k++) begin
      @(posedge clk);
      #1;
      n_checks++; if (s_fs !== (k == 600)) begin n_fail++;
        $display("FAIL midrst_frame_start k=%0d got %b exp %b", k, s_fs, (k == 600)); end
      if (k == 3) begin
        n_checks++; if (s_x !== 16'd0 || s_y !== 16'd0 || s_pt !== 1'b1) begin n_fail++;
          $display("FAIL midrst_restart k=3 got (%0d,%0d) pt=%b exp (0,0) 1", s_x, s_y, s_pt); end
      end
      if (k == 4) begin
        n_checks++; if (s_x !== 16'd1 || s_y !== 16'd0 || s_pt !== 1'b0) begin n_fail++;
          $display("FAIL midrst_first_step k=4 got (%0d,%0d) pt=%b exp (1,0) 0", s_x, s_y, s_pt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_scan();
    test_control();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter PIX_DIV, default 4, clk cycles per pixel; legal range 2..16.
REQ-006 clk  input  1  system clock; the only clock in the block.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 control0_in, control1_in, control2_in  input  3 each  requested 3-bit colour codes.
REQ-009 mode_in  input  1  requested mode: 0 = three vertical bands, 1 = full screen.
REQ-010 pixel_x, pixel_y  output  16 each  current horizontal and vertical count.
REQ-011 video_on  output  1  high inside the visible area.
REQ-012 hsync, vsync  output  1 each  active-low sync pulses.
REQ-013 p_tick  output  1  one-clk pulse per pixel period.
REQ-014 frame_start  output  1  one-clk pulse at frame wrap.
REQ-015 control0, control1, control2  output  3 each; mode  output  1; applied configuration for the pixel generator.

Function
REQ-016 Tick counter counts 0..PIX_DIV-1 every clk and wraps; p_tick = 1 while the counter equals PIX_DIV-1.
REQ-017 H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525 by default).
REQ-018 On each p_tick, pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments on the same edge.
REQ-019 pixel_y wraps from V_TOTAL-1 to 0 on the edge where pixel_x wraps and pixel_y equals V_TOTAL-1; both counts go to (0,0) on that single edge.
REQ-020 Counts are zero-extended to 16 bits and never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-021 hsync and vsync are registers loaded on the same edge as the counts, from the next-count values.
REQ-022 hsync = 0 iff pixel_x is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]; default range 656..751.
REQ-023 vsync = 0 iff pixel_y is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1]; default range 490..491.
REQ-024 video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY), decoded combinationally from the count registers (zero latency).
REQ-025 frame_start is a registered output, high for exactly one clk: the cycle immediately after the edge on which the counts wrap to (0,0).
REQ-026 frame_start is not asserted following reset; it first fires on the first wrap.

Reset
REQ-027 While reset_n = 0: tick counter = 0, pixel_x = pixel_y = 0, hsync = vsync = 1, p_tick = 0, frame_start = 0, control0..2 = 0, mode = 0.
REQ-028 Reset asserted mid-frame takes effect immediately, without waiting for clk. After release, counting restarts at (0,0) with the tick counter at 0.

Configuration
REQ-029 Macro FRAME_LATCH_EN, when defined: control0..2 and mode load from the *_in inputs only on the edge where the counts wrap to (0,0). Changes made mid-frame never appear within the current frame.
REQ-030 FRAME_LATCH_EN undefined: control0..2 and mode are registered copies of the *_in inputs, updated every clk with 1-clk latency.

Structure
REQ-031 Package vga_timing_pkg holds the default timing constants, H_TOTAL/V_TOTAL derivation functions, and the 3-bit colour-code localparams.
REQ-032 Sub-module pix_tick_div implements REQ-016 (parameter PIX_DIV; ports clk, reset_n, p_tick). All other logic lives in vga_sync_ctrl.

Verification
REQ-033 Reset release, default parameters, run 2 frames -> p_tick every 4 clks; 800x525 = 420000 p_ticks per frame; frame_start exactly once per frame, every 1680000 clks.
REQ-034 Line scan -> hsync low for exactly 96 p_ticks, pixel_x 656..751; video_on high for pixel_x 0..639 on lines 0..479 and low elsewhere.
REQ-035 Frame end -> vsync low on lines 490..491 only; (799,524) followed by (0,0) on one edge, with frame_start high the next clk.
REQ-036 FRAME_LATCH_EN defined, control0_in changes from 3'b001 to 3'b100 at line 200 -> control0 stays 3'b001 until the wrap, then becomes 3'b100. Undefined -> control0 becomes 3'b100 one clk after the change.
REQ-037 reset_n pulsed low at pixel (300,250) -> outputs reach reset values with no clk edge; after release, counting restarts at (0,0), and frame_start is absent until the next wrap.
